// File: rtl/tboom_free_list.sv
// Two-wide physical register free list for the TinyBOOM rename stage.
// Circular buffer of free physical regs with checkpointed head pointer for one-cycle recovery.
module tboom_free_list #(
   parameter int unsigned NUM_PHYS_REGS       = 64,
   parameter int unsigned NUM_ARCH_REGS       = 32,
   parameter int unsigned CHECKPOINT_DEPTH    = 8,
   parameter int unsigned REG_PHYS_ADDR_WIDTH = $clog2(NUM_PHYS_REGS)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                alloc_enable,
   input  logic                                i0_freelist_request,
   input  logic                                i1_freelist_request,
   output logic [REG_PHYS_ADDR_WIDTH-1:0]      i0_phys_rd,
   output logic [REG_PHYS_ADDR_WIDTH-1:0]      i1_phys_rd,
   output logic                                i0_alloc_valid,
   output logic                                i1_alloc_valid,
   output logic                                alloc_stall,
   input  logic                                free0_valid,
   input  logic                                free1_valid,
   input  logic [REG_PHYS_ADDR_WIDTH-1:0]      free0_phys,
   input  logic [REG_PHYS_ADDR_WIDTH-1:0]      free1_phys,
   input  logic                                checkpoint,
   input  logic                                restore,
   input  logic [$clog2(CHECKPOINT_DEPTH)-1:0] checkpoint_restore_pos,
   output logic [REG_PHYS_ADDR_WIDTH:0]        free_count,
   output logic                                overflow_err
);

   localparam int unsigned AW      = REG_PHYS_ADDR_WIDTH;
   localparam int unsigned PW      = AW + 1;
   localparam int unsigned NumInit = NUM_PHYS_REGS - NUM_ARCH_REGS;

   logic [AW-1:0] entry_q [NUM_PHYS_REGS];
   logic [AW-1:0] entry_d [NUM_PHYS_REGS];
   logic [PW-1:0] ckpt_q  [CHECKPOINT_DEPTH];
   logic [PW-1:0] ckpt_d  [CHECKPOINT_DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PW-1:0] head_p1, head_adv, tail_wr1;
   logic          overflow_q, overflow_d;
   logic [1:0]    need;
   logic          req_free0, req_free1, acc0, acc1;

   // Allocation side: purely combinational from registered pointers.
   always_comb begin
      free_count     = tail_q - head_q;
      need           = {1'b0, i0_freelist_request} + {1'b0, i1_freelist_request};
      alloc_stall    = restore || (PW'(need) > free_count);
      i0_alloc_valid = i0_freelist_request && alloc_enable && !alloc_stall;
      i1_alloc_valid = i1_freelist_request && alloc_enable && !alloc_stall;
      head_p1        = head_q + PW'(1);
      i0_phys_rd     = entry_q[head_q[AW-1:0]];
      i1_phys_rd     = i0_freelist_request ? entry_q[head_p1[AW-1:0]]
                                           : entry_q[head_q[AW-1:0]];
      head_adv       = head_q + PW'(i0_alloc_valid) + PW'(i1_alloc_valid);
      head_d         = restore ? ckpt_q[checkpoint_restore_pos] : head_adv;
      overflow_err   = overflow_q;
   end

   // Checkpoints capture the post-dequeue head; a restore in the same cycle suppresses the save.
   always_comb begin
      ckpt_d = ckpt_q;
      if (checkpoint && !restore) begin
         ckpt_d[checkpoint_restore_pos] = head_adv;
      end
   end

   // Reclaim side: phys 0 is never a valid free; anything past a full list is dropped.
   always_comb begin
      req_free0  = free0_valid && (free0_phys != '0);
      req_free1  = free1_valid && (free1_phys != '0);
      acc0       = req_free0 && (free_count < PW'(NUM_PHYS_REGS));
      acc1       = req_free1 && ((free_count + PW'(acc0)) < PW'(NUM_PHYS_REGS));
      tail_wr1   = tail_q + PW'(acc0);
      tail_d     = tail_wr1 + PW'(acc1);
      overflow_d = overflow_q || (req_free0 && !acc0) || (req_free1 && !acc1);
      entry_d    = entry_q;
      if (acc0) begin
         entry_d[tail_q[AW-1:0]] = free0_phys;
      end
      if (acc1) begin
         entry_d[tail_wr1[AW-1:0]] = free1_phys;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < int'(NUM_PHYS_REGS); k++) begin
            entry_q[k] <= (k < int'(NumInit)) ? AW'(int'(NUM_ARCH_REGS) + k) : '0;
         end
         for (int c = 0; c < int'(CHECKPOINT_DEPTH); c++) begin
            ckpt_q[c] <= '0;
         end
         head_q     <= '0;
         tail_q     <= PW'(NumInit);
         overflow_q <= 1'b0;
      end else begin
         entry_q    <= entry_d;
         ckpt_q     <= ckpt_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_tboom_free_list.sv
// Directed testbench for tboom_free_list: allocation, stall, checkpoint/restore, wrap, overflow.
module tb_tboom_free_list;

   logic       clk;
   logic       rst;
   logic       alloc_enable;
   logic       i0_freelist_request, i1_freelist_request;
   logic [5:0] i0_phys_rd, i1_phys_rd;
   logic       i0_alloc_valid, i1_alloc_valid, alloc_stall;
   logic       free0_valid, free1_valid;
   logic [5:0] free0_phys, free1_phys;
   logic       checkpoint, restore;
   logic [2:0] checkpoint_restore_pos;
   logic [6:0] free_count;
   logic       overflow_err;

   int n_cmp;
   int n_bad;

   tboom_free_list dut (
      .clk                    (clk),
      .rst                    (rst),
      .alloc_enable           (alloc_enable),
      .i0_freelist_request    (i0_freelist_request),
      .i1_freelist_request    (i1_freelist_request),
      .i0_phys_rd             (i0_phys_rd),
      .i1_phys_rd             (i1_phys_rd),
      .i0_alloc_valid         (i0_alloc_valid),
      .i1_alloc_valid         (i1_alloc_valid),
      .alloc_stall            (alloc_stall),
      .free0_valid            (free0_valid),
      .free1_valid            (free1_valid),
      .free0_phys             (free0_phys),
      .free1_phys             (free1_phys),
      .checkpoint             (checkpoint),
      .restore                (restore),
      .checkpoint_restore_pos (checkpoint_restore_pos),
      .free_count             (free_count),
      .overflow_err           (overflow_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idle();
      alloc_enable           = 1'b0;
      i0_freelist_request    = 1'b0;
      i1_freelist_request    = 1'b0;
      free0_valid            = 1'b0;
      free1_valid            = 1'b0;
      free0_phys             = '0;
      free1_phys             = '0;
      checkpoint             = 1'b0;
      restore                = 1'b0;
      checkpoint_restore_pos = '0;
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit after posedge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic alloc_pair();
      idle();
      alloc_enable        = 1'b1;
      i0_freelist_request = 1'b1;
      i1_freelist_request = 1'b1;
      step();
      idle();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (free_count !== 7'd32) begin n_bad++; $display("FAIL reset_count: got %0d expected 32", free_count); end
      n_cmp++; if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %0d expected 0", overflow_err); end
      n_cmp++; if (alloc_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0d expected 0", alloc_stall); end
      n_cmp++; if (i0_phys_rd !== 6'd32) begin n_bad++; $display("FAIL reset_i0: got %0d expected 32", i0_phys_rd); end
   endtask

   task automatic test_dual_alloc();
      do_reset();
      alloc_enable = 1'b1; i0_freelist_request = 1'b1; i1_freelist_request = 1'b1;
      #1;
      n_cmp++; if (i0_phys_rd !== 6'd32) begin n_bad++; $display("FAIL dual_i0: got %0d expected 32", i0_phys_rd); end
      n_cmp++; if (i1_phys_rd !== 6'd33) begin n_bad++; $display("FAIL dual_i1: got %0d expected 33", i1_phys_rd); end
      n_cmp++; if ({i0_alloc_valid, i1_alloc_valid} !== 2'b11) begin n_bad++; $display("FAIL dual_valid: got %b expected 11", {i0_alloc_valid, i1_alloc_valid}); end
      step(); idle(); #1;
      n_cmp++; if (free_count !== 7'd30) begin n_bad++; $display("FAIL dual_count: got %0d expected 30", free_count); end
      n_cmp++; if (i0_phys_rd !== 6'd34) begin n_bad++; $display("FAIL dual_next_i0: got %0d expected 34", i0_phys_rd); end
   endtask

   task automatic test_single_i1();
      do_reset();
      alloc_enable = 1'b1; i1_freelist_request = 1'b1;
      #1;
      n_cmp++; if (i1_phys_rd !== 6'd32) begin n_bad++; $display("FAIL single_i1: got %0d expected 32", i1_phys_rd); end
      n_cmp++; if ({i0_alloc_valid, i1_alloc_valid} !== 2'b01) begin n_bad++; $display("FAIL single_valid: got %b expected 01", {i0_alloc_valid, i1_alloc_valid}); end
      step(); idle(); #1;
      n_cmp++; if (free_count !== 7'd31) begin n_bad++; $display("FAIL single_count: got %0d expected 31", free_count); end
      n_cmp++; if (i0_phys_rd !== 6'd33) begin n_bad++; $display("FAIL single_next_i0: got %0d expected 33", i0_phys_rd); end
      // Requests without alloc_enable must not dequeue.
      i0_freelist_request = 1'b1; i1_freelist_request = 1'b1;
      #1;
      n_cmp++; if ({i0_alloc_valid, i1_alloc_valid, alloc_stall} !== 3'b000) begin n_bad++; $display("FAIL noen_valid: got %b expected 000", {i0_alloc_valid, i1_alloc_valid, alloc_stall}); end
      step(); idle(); #1;
      n_cmp++; if (free_count !== 7'd31) begin n_bad++; $display("FAIL noen_count: got %0d expected 31", free_count); end
   endtask

   task automatic test_stall();
      do_reset();
      for (int i = 0; i < 15; i++) alloc_pair();
      alloc_enable = 1'b1; i0_freelist_request = 1'b1;
      step(); idle(); #1;
      n_cmp++; if (free_count !== 7'd1) begin n_bad++; $display("FAIL drain_count: got %0d expected 1", free_count); end
      alloc_enable = 1'b1; i0_freelist_request = 1'b1; i1_freelist_request = 1'b1;
      free0_valid = 1'b1; free0_phys = 6'd40;
      #1;
      n_cmp++; if ({alloc_stall, i0_alloc_valid, i1_alloc_valid} !== 3'b100) begin n_bad++; $display("FAIL stall_flags: got %b expected 100", {alloc_stall, i0_alloc_valid, i1_alloc_valid}); end
      step();
      free0_valid = 1'b0; free0_phys = '0;
      #1;
      n_cmp++; if (free_count !== 7'd2) begin n_bad++; $display("FAIL stall_count: got %0d expected 2", free_count); end
      n_cmp++; if ({alloc_stall, i0_alloc_valid, i1_alloc_valid} !== 3'b011) begin n_bad++; $display("FAIL unstall_flags: got %b expected 011", {alloc_stall, i0_alloc_valid, i1_alloc_valid}); end
      n_cmp++; if (i0_phys_rd !== 6'd63) begin n_bad++; $display("FAIL unstall_i0: got %0d expected 63", i0_phys_rd); end
      n_cmp++; if (i1_phys_rd !== 6'd40) begin n_bad++; $display("FAIL unstall_i1: got %0d expected 40", i1_phys_rd); end
      step(); idle(); #1;
      n_cmp++; if (free_count !== 7'd0) begin n_bad++; $display("FAIL empty_count: got %0d expected 0", free_count); end
      n_cmp++; if (alloc_stall !== 1'b0) begin n_bad++; $display("FAIL empty_noreq_stall: got %0d expected 0", alloc_stall); end
      alloc_enable = 1'b1; i0_freelist_request = 1'b1;
      #1;
      n_cmp++; if ({alloc_stall, i0_alloc_valid} !== 2'b10) begin n_bad++; $display("FAIL empty_stall: got %b expected 10", {alloc_stall, i0_alloc_valid}); end
      idle();
   endtask

   task automatic test_checkpoint_restore();
      do_reset();
      alloc_pair(); alloc_pair();
      checkpoint = 1'b1; checkpoint_restore_pos = 3'd3;
      step(); idle();
      for (int i = 0; i < 3; i++) alloc_pair();
      #1;
      n_cmp++; if (free_count !== 7'd22) begin n_bad++; $display("FAIL pre_restore_count: got %0d expected 22", free_count); end
      alloc_enable = 1'b1; i0_freelist_request = 1'b1; i1_freelist_request = 1'b1;
      restore = 1'b1; checkpoint_restore_pos = 3'd3;
      free0_valid = 1'b1; free0_phys = 6'd5;
      #1;
      n_cmp++; if ({alloc_stall, i0_alloc_valid, i1_alloc_valid} !== 3'b100) begin n_bad++; $display("FAIL restore_flags: got %b expected 100", {alloc_stall, i0_alloc_valid, i1_alloc_valid}); end
      step(); idle(); #1;
      n_cmp++; if (free_count !== 7'd29) begin n_bad++; $display("FAIL restore_count: got %0d expected 29", free_count); end
      n_cmp++; if (i0_phys_rd !== 6'd36) begin n_bad++; $display("FAIL restore_i0: got %0d expected 36", i0_phys_rd); end
      // Checkpoint alongside a dequeue saves the advanced head (6).
      alloc_enable = 1'b1; i0_freelist_request = 1'b1; i1_freelist_request = 1'b1;
      checkpoint = 1'b1; checkpoint_restore_pos = 3'd5;
      step(); idle();
      alloc_pair();
      restore = 1'b1; checkpoint = 1'b1; checkpoint_restore_pos = 3'd5;
      step(); idle(); #1;
      n_cmp++; if (i0_phys_rd !== 6'd38) begin n_bad++; $display("FAIL ckpt_dequeue_i0: got %0d expected 38", i0_phys_rd); end
      alloc_pair();
      restore = 1'b1; checkpoint_restore_pos = 3'd5;
      step(); idle(); #1;
      n_cmp++; if (i0_phys_rd !== 6'd38) begin n_bad++; $display("FAIL restore_wins_i0: got %0d expected 38", i0_phys_rd); end
      n_cmp++; if (free_count !== 7'd27) begin n_bad++; $display("FAIL restore_wins_count: got %0d expected 27", free_count); end
   endtask

   task automatic test_wrap();
      int q[$];
      int exp_cnt;
      int e0, e1, p0, p1;
      bit have_prev;
      do_reset();
      free0_valid = 1'b1; free1_valid = 1'b1;
      step(); idle(); #1;
      n_cmp++; if (free_count !== 7'd32) begin n_bad++; $display("FAIL free_zero_count: got %0d expected 32", free_count); end
      for (int k = 32; k < 64; k++) q.push_back(k);
      exp_cnt   = 32;
      have_prev = 1'b0;
      p0 = 0; p1 = 0;
      for (int c = 0; c < 70; c++) begin
         alloc_enable = 1'b1; i0_freelist_request = 1'b1; i1_freelist_request = 1'b1;
         free0_valid = have_prev; free1_valid = have_prev;
         free0_phys = 6'(p0); free1_phys = 6'(p1);
         #1;
         e0 = q.pop_front();
         e1 = q.pop_front();
         n_cmp++; if (free_count !== 7'(exp_cnt)) begin n_bad++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", c, free_count, exp_cnt); end
         n_cmp++; if ({i0_alloc_valid, i1_alloc_valid, i0_phys_rd, i1_phys_rd} !== {2'b11, 6'(e0), 6'(e1)}) begin
            n_bad++;
            $display("FAIL wrap_grant[%0d]: got v=%b %0d,%0d expected v=11 %0d,%0d", c, {i0_alloc_valid, i1_alloc_valid}, i0_phys_rd, i1_phys_rd, e0, e1);
         end
         if (have_prev) begin
            q.push_back(p0);
            q.push_back(p1);
         end
         exp_cnt   = exp_cnt - 2 + (have_prev ? 2 : 0);
         p0        = e0;
         p1        = e1;
         have_prev = 1'b1;
         step();
      end
      idle();
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         free0_valid = 1'b1; free0_phys = 6'(2 * i + 1);
         free1_valid = 1'b1; free1_phys = 6'(2 * i + 2);
         step();
      end
      idle(); #1;
      n_cmp++; if (free_count !== 7'd64) begin n_bad++; $display("FAIL full_count: got %0d expected 64", free_count); end
      n_cmp++; if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL full_ovf: got %0d expected 0", overflow_err); end
      free0_valid = 1'b1; free0_phys = 6'd5;
      step(); idle(); #1;
      n_cmp++; if ({overflow_err, free_count} !== {1'b1, 7'd64}) begin n_bad++; $display("FAIL ovf_set: got ovf=%0d cnt=%0d expected ovf=1 cnt=64", overflow_err, free_count); end
      step();
      alloc_enable = 1'b1; i0_freelist_request = 1'b1; i1_freelist_request = 1'b1;
      #1;
      n_cmp++; if ({i0_phys_rd, i1_phys_rd} !== {6'd32, 6'd33}) begin n_bad++; $display("FAIL full_grant: got %0d,%0d expected 32,33", i0_phys_rd, i1_phys_rd); end
      step(); idle(); #1;
      n_cmp++; if ({overflow_err, free_count} !== {1'b1, 7'd62}) begin n_bad++; $display("FAIL ovf_sticky: got ovf=%0d cnt=%0d expected ovf=1 cnt=62", overflow_err, free_count); end
   endtask

   task automatic test_reset_mid();
      alloc_enable = 1'b1; i0_freelist_request = 1'b1; i1_freelist_request = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0; idle(); #1;
      n_cmp++; if ({overflow_err, free_count} !== {1'b0, 7'd32}) begin n_bad++; $display("FAIL mid_reset: got ovf=%0d cnt=%0d expected ovf=0 cnt=32", overflow_err, free_count); end
      n_cmp++; if (i0_phys_rd !== 6'd32) begin n_bad++; $display("FAIL mid_reset_i0: got %0d expected 32", i0_phys_rd); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      idle();
      step();
      test_reset();
      test_dual_alloc();
      test_single_i1();
      test_stall();
      test_checkpoint_restore();
      test_wrap();
      test_overflow();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tboom_free_list.md
# tboom_free_list

Two-wide physical register free list for the TinyBOOM rename stage. It supplies a fresh physical destination register to each rename slot that raises a freelist request from the rename map table, and reclaims stale physical registers released at commit. It saves and restores its allocation head pointer in step with the rename map table checkpoints so that branch-misprediction recovery returns speculatively allocated registers in one cycle.

## Interface
- NUM_PHYS_REGS, 64: physical register count; power of two.
- NUM_ARCH_REGS, 32: architectural register count; physical regs 0..NUM_ARCH_REGS-1 are mapped at reset.
- CHECKPOINT_DEPTH, 8: number of head-pointer checkpoint slots.
- REG_PHYS_ADDR_WIDTH, $clog2(NUM_PHYS_REGS): physical register index width.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- alloc_enable  in  1  rename stage is advancing this cycle; no dequeue when low.
- i0_freelist_request  in  1  slot 0 needs a destination register.
- i1_freelist_request  in  1  slot 1 needs a destination register.
- i0_phys_rd  out  REG_PHYS_ADDR_WIDTH  register granted to slot 0.
- i1_phys_rd  out  REG_PHYS_ADDR_WIDTH  register granted to slot 1.
- i0_alloc_valid / i1_alloc_valid  out  1 each  grant qualifier per slot.
- alloc_stall  out  1  insufficient free registers or restore in progress; rename must hold.
- free0_valid / free1_valid  in  1 each  commit releases a stale register.
- free0_phys / free1_phys  in  REG_PHYS_ADDR_WIDTH each  register being released.
- checkpoint  in  1  save head pointer into slot checkpoint_restore_pos.
- restore  in  1  reload head pointer from slot checkpoint_restore_pos.
- checkpoint_restore_pos  in  $clog2(CHECKPOINT_DEPTH)  checkpoint slot index.
- free_count  out  REG_PHYS_ADDR_WIDTH+1  registers currently free.
- overflow_err  out  1  sticky: a free was attempted with the list full.

## Operation
- Storage: circular buffer of NUM_PHYS_REGS entries; head/tail pointers REG_PHYS_ADDR_WIDTH+1 bits (wrap bit + index); free_count = tail - head, modulo 2^(REG_PHYS_ADDR_WIDTH+1).
- Reset: entry k holds NUM_ARCH_REGS+k for k = 0..NUM_PHYS_REGS-NUM_ARCH_REGS-1; head = 0; tail = NUM_PHYS_REGS-NUM_ARCH_REGS; all checkpoint slots = 0; overflow_err = 0.
- need = i0_freelist_request + i1_freelist_request (0..2).
- alloc_stall = restore || (need > free_count). All-or-nothing: never grant one slot of a pair and stall the other.
- Grant: iX_alloc_valid = iX_freelist_request && alloc_enable && !alloc_stall.
- Output mapping: i0_phys_rd = entry[head]; i1_phys_rd = entry[head+1] if i0_freelist_request else entry[head]. Outputs are driven regardless of valid.
- Dequeue: head += number of asserted alloc_valid.
- Free: free0 then free1 written at tail, tail+1 in that order; if only free1 valid it is written at tail. free_phys == 0 is ignored. A free that would make free_count exceed NUM_PHYS_REGS is dropped and sets overflow_err (cleared only by rst).
- Checkpoint: slot[pos] := head after this cycle's dequeue (the next head value).
- Restore: head := slot[pos]; no dequeue that cycle; frees still enqueue; tail never restored.
- checkpoint && restore same cycle: restore wins, checkpoint ignored.

## Timing
- Allocation is zero-latency: i*_phys_rd / i*_alloc_valid / alloc_stall are combinational from the current head, tail and requests, in the same cycle the rename map table writes.
- Frees are visible in free_count and allocatable the cycle after free*_valid (no same-cycle bypass).
- Restore takes effect on the next edge; the first post-restore allocation is the cycle after restore.
- free_count reflects registered pointers only (post-edge value).
- Reset mid-operation: all pointers, checkpoints and overflow_err return to reset values on the edge where rst is high; outputs show reset state the following cycle.
- Pointer wrap-around at NUM_PHYS_REGS is transparent; full (count = NUM_PHYS_REGS) and empty (count = 0) are distinguished by the wrap bit.

## Test plan
- Reset, request both slots with alloc_enable=1 -> i0_phys_rd=32, i1_phys_rd=33, both valid; next cycle free_count=30.
- Only i1 requests after reset -> i1_phys_rd=32, i0_alloc_valid=0, free_count becomes 31.
- Drain to free_count=1, request both -> alloc_stall=1, no grants, head unchanged; free0_phys=40 in that cycle -> next cycle both granted.
- Checkpoint slot 3 at head=4, allocate 6 regs, restore slot 3 with free0_valid=1 -> alloc_stall=1 that cycle, next cycle i0_phys_rd equals entry[4], free_count = prior count at checkpoint +1.
- Cycle 70 allocs/frees so pointers wrap -> grants continue in FIFO order, free_count never miscounts; free of phys 0 leaves count unchanged.
- Free into full list (count=64) -> entry dropped, overflow_err=1 and stays high until rst.
